// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 3-stage core: r1 halt/flush and PC stall generation
// for memory wait, taken branch, load-use hazard and HALT, plus stall/timeout status.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       src_a,
  input  logic             src_a_vld,
  input  logic [2:0]       src_b,
  input  logic             src_b_vld,
  input  logic             dec_halt,
  input  logic [2:0]       r1_destination,
  input  logic             r1_wr_en,
  input  logic             r1_is_load,
  input  logic             branch_taken,
  input  logic             mem_wait,
  input  logic             resume,
  output logic             pc_stall,
  output logic             r1_halt,
  output logic             r1_flush,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WC_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LIMIT   = WC_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              lu;

  assign lu = r1_is_load & r1_wr_en &
              ((src_a_vld & (src_a == r1_destination)) |
               (src_b_vld & (src_b == r1_destination)));

  // Next state and combinational controls; mem_wait overrides every state.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_stall    = 1'b0;
    r1_halt     = 1'b0;
    r1_flush    = 1'b0;
    if (rst) begin
      state_d     = S_RUN;
      flush_cnt_d = '0;
    end else if (mem_wait) begin
      pc_stall = 1'b1;
      r1_halt  = 1'b1;
      if (state_q == S_RUN) state_d = S_WAIT;
    end else begin
      unique case (state_q)
        S_RUN, S_WAIT: begin
          state_d = S_RUN;
          if (branch_taken) begin
            r1_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_d = FLUSH_RELOAD;
              state_d     = S_FLUSH;
            end
          end else if (lu) begin
            pc_stall = 1'b1;
            r1_flush = 1'b1;
          end else if (dec_halt) begin
            pc_stall = 1'b1;
            r1_flush = 1'b1;
            state_d  = S_HALTED;
          end
        end
        S_FLUSH: begin
          r1_flush = 1'b1;
          if (branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q == FC_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = S_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
        S_HALTED: begin
          pc_stall = 1'b1;
          r1_flush = 1'b1;
          if (resume) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Consecutive mem_wait cycles, saturating; the timeout flag is sticky.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
    end
    timeout_d   = timeout_q | (mem_wait & (wait_cnt_d == WAIT_LIMIT));
    halted_d    = (state_d == S_HALTED);
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted      = halted_q;
  assign timeout_err = timeout_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: FLUSH_CYCLES=3, MAX_WAIT=5, CNT_W=5
// so that the multi-cycle flush, timeout and counter saturation are all reachable.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic [2:0]       src_a, src_b, r1_destination;
  logic             src_a_vld, src_b_vld, dec_halt, r1_wr_en, r1_is_load;
  logic             branch_taken, mem_wait, resume;
  logic             pc_stall, r1_halt, r1_flush, halted, timeout_err;
  logic [CNT_W-1:0] stall_count;

  int n_pass  = 0;
  int n_total = 0;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .MAX_WAIT    (5),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_a         (src_a),
    .src_a_vld     (src_a_vld),
    .src_b         (src_b),
    .src_b_vld     (src_b_vld),
    .dec_halt      (dec_halt),
    .r1_destination(r1_destination),
    .r1_wr_en      (r1_wr_en),
    .r1_is_load    (r1_is_load),
    .branch_taken  (branch_taken),
    .mem_wait      (mem_wait),
    .resume        (resume),
    .pc_stall      (pc_stall),
    .r1_halt       (r1_halt),
    .r1_flush      (r1_flush),
    .halted        (halted),
    .timeout_err   (timeout_err),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_comb(input string tag, input logic ps, input logic rh, input logic rf);
    chk({tag, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, ps});
    chk({tag, ".r1_halt"},  {31'd0, r1_halt},  {31'd0, rh});
    chk({tag, ".r1_flush"}, {31'd0, r1_flush}, {31'd0, rf});
  endtask

  task automatic clear_in();
    src_a = 3'd0; src_a_vld = 1'b0; src_b = 3'd0; src_b_vld = 1'b0;
    dec_halt = 1'b0; r1_destination = 3'd0; r1_wr_en = 1'b0; r1_is_load = 1'b0;
    branch_taken = 1'b0; mem_wait = 1'b0; resume = 1'b0;
  endtask

  // Advance past the next rising edge; inputs are driven and registers read here.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    nxt();

    // Reset with every input high: combinational outputs forced low
    src_a = 3'd7; src_a_vld = 1'b1; src_b = 3'd7; src_b_vld = 1'b1;
    dec_halt = 1'b1; r1_destination = 3'd7; r1_wr_en = 1'b1; r1_is_load = 1'b1;
    branch_taken = 1'b1; mem_wait = 1'b1; resume = 1'b1;
    repeat (2) begin
      #4 chk_comb("rst", 1'b0, 1'b0, 1'b0);
      nxt();
    end
    chk("rst_halted",  {31'd0, halted}, 0);
    chk("rst_timeout", {31'd0, timeout_err}, 0);
    chk("rst_count",   {27'd0, stall_count}, 0);
    rst = 1'b0;
    clear_in();

    // Load-use hazard on operand B, then no hazard when B is not used
    r1_is_load = 1'b1; r1_wr_en = 1'b1; r1_destination = 3'd3;
    src_b = 3'd3; src_b_vld = 1'b1;
    #4 chk_comb("lu_b", 1'b1, 1'b0, 1'b1);
    nxt();
    chk("lu_b_count", {27'd0, stall_count}, 1);
    src_b_vld = 1'b0;
    #4 chk_comb("lu_b_novld", 1'b0, 1'b0, 1'b0);
    nxt();
    chk("novld_count", {27'd0, stall_count}, 1);
    src_a = 3'd3; src_a_vld = 1'b1; src_b = 3'd5; src_b_vld = 1'b1;
    #4 chk_comb("lu_a", 1'b1, 1'b0, 1'b1);
    nxt();
    chk("lu_a_count", {27'd0, stall_count}, 2);
    r1_wr_en = 1'b0;
    #4 chk_comb("lu_nowr", 1'b0, 1'b0, 1'b0);
    nxt();
    r1_wr_en = 1'b1; r1_destination = 3'd4;
    #4 chk_comb("lu_nomatch", 1'b0, 1'b0, 1'b0);
    nxt();
    clear_in();

    // Taken branch wins over a simultaneous load-use hazard; 3 flush cycles
    r1_is_load = 1'b1; r1_wr_en = 1'b1; r1_destination = 3'd3;
    src_a = 3'd3; src_a_vld = 1'b1; branch_taken = 1'b1;
    #4 chk_comb("br_prio", 1'b0, 1'b0, 1'b1);
    nxt();
    clear_in();
    repeat (2) begin
      #4 chk_comb("br_flush", 1'b0, 1'b0, 1'b1);
      nxt();
    end
    #4 chk_comb("br_done", 1'b0, 1'b0, 1'b0);
    nxt();
    chk("br_count", {27'd0, stall_count}, 2);

    // mem_wait overrides a pending branch for 4 cycles, then the branch flushes
    mem_wait = 1'b1; branch_taken = 1'b1;
    repeat (4) begin
      #4 chk_comb("mw_hold", 1'b1, 1'b1, 1'b0);
      nxt();
    end
    chk("mw_count",   {27'd0, stall_count}, 6);
    chk("mw_timeout", {31'd0, timeout_err}, 0);
    mem_wait = 1'b0;
    #4 chk_comb("mw_br", 1'b0, 1'b0, 1'b1);
    nxt();
    branch_taken = 1'b0;
    repeat (2) begin
      #4 chk_comb("mw_br_flush", 1'b0, 1'b0, 1'b1);
      nxt();
    end
    #4 chk_comb("mw_br_done", 1'b0, 1'b0, 1'b0);
    nxt();

    // Timeout: sets after the 5th consecutive wait cycle and stays set
    mem_wait = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      nxt();
      chk($sformatf("timeout_%0d", i), {31'd0, timeout_err}, (i >= 5) ? 1 : 0);
    end
    mem_wait = 1'b0;
    nxt();
    chk("timeout_sticky", {31'd0, timeout_err}, 1);
    chk("to_count",       {27'd0, stall_count}, 13);

    // HALT entry, hold, mem_wait while halted, resume
    dec_halt = 1'b1;
    #4 chk_comb("halt_enter", 1'b1, 1'b0, 1'b1);
    nxt();
    dec_halt = 1'b0;
    chk("halted_set", {31'd0, halted}, 1);
    repeat (10) begin
      #4 chk_comb("halted", 1'b1, 1'b0, 1'b1);
      nxt();
    end
    chk("halted_held", {31'd0, halted}, 1);
    chk("halt_count",  {27'd0, stall_count}, 24);
    mem_wait = 1'b1;
    #4 chk_comb("halt_mw", 1'b1, 1'b1, 1'b0);
    nxt();
    mem_wait = 1'b0;
    chk("halt_mw_halted", {31'd0, halted}, 1);
    resume = 1'b1;
    #4 chk_comb("resume_cyc", 1'b1, 1'b0, 1'b1);
    nxt();
    resume = 1'b0;
    chk("resumed",       {31'd0, halted}, 0);
    chk("resume_count",  {27'd0, stall_count}, 26);
    #4 chk_comb("run_after", 1'b0, 1'b0, 1'b0);
    nxt();

    // Halt again until the counter saturates, then reset while halted
    dec_halt = 1'b1;
    nxt();
    dec_halt = 1'b0;
    repeat (4) nxt();
    chk("count_max", {27'd0, stall_count}, 31);
    repeat (2) nxt();
    chk("count_sat", {27'd0, stall_count}, 31);
    chk("timeout_kept", {31'd0, timeout_err}, 1);
    rst = 1'b1;
    #4 chk_comb("rst_in_halt", 1'b0, 1'b0, 1'b0);
    nxt();
    rst = 1'b0;
    chk("rst2_halted",  {31'd0, halted}, 0);
    chk("rst2_count",   {27'd0, stall_count}, 0);
    chk("rst2_timeout", {31'd0, timeout_err}, 0);
    #4 chk_comb("post_rst_run", 1'b0, 1'b0, 1'b0);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
